// File: rtl/alu_issue_ctrl.sv
// Issue sequencer in front of the 32-bit ALU: latches one instruction, owns the NZCV register,
// stalls for MUL, runs the LDR/STR memory handshake. Define ALU_ISSUE_PERF_EN for retire/skip counters.
module alu_issue_ctrl #(
    parameter int MUL_LAT = 3,
    parameter int DATA_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_cond,
    input  logic [3:0]        in_opcode,
    input  logic              in_sbit,
    input  logic [2:0]        in_srcontrol,
    input  logic [15:0]       in_imvalue,
    input  logic [DATA_W-1:0] in_op1,
    input  logic [DATA_W-1:0] in_op2,
    output logic [DATA_W-1:0] alu_in1,
    output logic [DATA_W-1:0] alu_in2,
    output logic [3:0]        alu_cond,
    output logic [3:0]        alu_opcode,
    output logic              alu_sbit,
    output logic [2:0]        alu_srcontrol,
    output logic [15:0]       alu_imvalue,
    output logic [3:0]        alu_inflags,
    input  logic [DATA_W-1:0] alu_result,
    input  logic [3:0]        alu_outflags,
    output logic              mem_req,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_wb_en,
    output logic [3:0]        flags,
`ifdef ALU_ISSUE_PERF_EN
    output logic [31:0]       perf_retired,
    output logic [31:0]       perf_skipped,
`endif
    output logic              busy
);

    localparam logic [3:0] OP_MUL = 4'b0010;
    localparam logic [3:0] OP_CMP = 4'b1000;
    localparam logic [3:0] OP_LDR = 4'b1001;
    localparam logic [3:0] OP_STR = 4'b1010;
    localparam int CNT_W = (MUL_LAT < 2) ? 1 : $clog2(MUL_LAT);
    localparam logic [CNT_W-1:0] MUL_LAST = CNT_W'(MUL_LAT - 1);

    typedef enum logic [1:0] {IDLE, EXEC, MEM, DONE} state_t;

    state_t            state;
    logic [3:0]        cond_p0;
    logic [3:0]        opcode_p0;
    logic              sbit_p0;
    logic [2:0]        srcontrol_p0;
    logic [15:0]       imvalue_p0;
    logic [DATA_W-1:0] op1_p0;
    logic [DATA_W-1:0] op2_p0;
    logic [CNT_W-1:0]  mul_cnt;
    logic              cond_met;
    logic              is_nop;
    logic              is_mem;
    logic              upd_flags;

    // Flag layout is {N,Z,C,V}.
    function automatic logic cond_check(input logic [3:0] cond, input logic [3:0] nzcv);
        logic n, z, c, v;
        {n, z, c, v} = nzcv;
        case (cond)
            4'b0001: cond_check = z;
            4'b0010: cond_check = !z && (n == v);
            4'b0011: cond_check = !z && (n != v);
            4'b0100: cond_check = (n == v);
            4'b0101: cond_check = (n != v);
            4'b0110: cond_check = !z && c;
            4'b0111: cond_check = !c;
            4'b1000: cond_check = c;
            default: cond_check = 1'b1;
        endcase
    endfunction

    assign cond_met  = cond_check(cond_p0, flags);
    assign is_nop    = (opcode_p0 > OP_STR);
    assign is_mem    = (opcode_p0 == OP_LDR) || (opcode_p0 == OP_STR);
    assign upd_flags = (opcode_p0 == OP_CMP) || (sbit_p0 && !is_nop && !is_mem);

    assign in_ready      = (state == IDLE);
    assign busy          = (state != IDLE);
    assign alu_in1       = op1_p0;
    assign alu_in2       = op2_p0;
    assign alu_cond      = cond_p0;
    assign alu_opcode    = opcode_p0;
    assign alu_sbit      = sbit_p0;
    assign alu_srcontrol = srcontrol_p0;
    assign alu_imvalue   = imvalue_p0;
    assign alu_inflags   = flags;
    assign mem_addr      = op1_p0 + DATA_W'(imvalue_p0);
    assign mem_wdata     = op2_p0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cond_p0      <= '0;
            opcode_p0    <= '0;
            sbit_p0      <= 1'b0;
            srcontrol_p0 <= '0;
            imvalue_p0   <= '0;
            op1_p0       <= '0;
            op2_p0       <= '0;
            mul_cnt      <= '0;
            flags        <= 4'b0000;
            mem_req      <= 1'b0;
            mem_we       <= 1'b0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_wb_en    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        cond_p0      <= in_cond;
                        opcode_p0    <= in_opcode;
                        sbit_p0      <= in_sbit;
                        srcontrol_p0 <= in_srcontrol;
                        imvalue_p0   <= in_imvalue;
                        op1_p0       <= in_op1;
                        op2_p0       <= in_op2;
                        mul_cnt      <= '0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (!cond_met) begin
                        out_result <= '0;
                        out_wb_en  <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end else if ((opcode_p0 == OP_MUL) && (mul_cnt != MUL_LAST)) begin
                        mul_cnt <= mul_cnt + 1'b1;
                    end else if (is_mem) begin
                        mem_req <= 1'b1;
                        mem_we  <= (opcode_p0 == OP_STR);
                        state   <= MEM;
                    end else begin
                        out_result <= is_nop ? '0 : alu_result;
                        out_wb_en  <= !is_nop && (opcode_p0 != OP_CMP);
                        if (upd_flags)
                            flags <= alu_outflags;
                        mul_cnt   <= '0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        out_result <= (opcode_p0 == OP_STR) ? '0 : mem_rdata;
                        out_wb_en  <= (opcode_p0 != OP_STR);
                        mem_req    <= 1'b0;
                        mem_we     <= 1'b0;
                        out_valid  <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef ALU_ISSUE_PERF_EN
    logic executed;

    // cond_met is frozen across EXEC, so its value there is the instruction's verdict.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            executed     <= 1'b0;
            perf_retired <= '0;
            perf_skipped <= '0;
        end else begin
            if (state == EXEC)
                executed <= cond_met;
            if ((state == DONE) && out_ready) begin
                if (executed)
                    perf_retired <= perf_retired + 32'd1;
                else
                    perf_skipped <= perf_skipped + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl: vector table of ALU ops plus hand sequences for memory,
// backpressure and reset; perf counters are checked when ALU_ISSUE_PERF_EN is defined.
module tb_alu_issue_ctrl;
    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready;
    logic [3:0]  in_cond, in_opcode;
    logic        in_sbit;
    logic [2:0]  in_srcontrol;
    logic [15:0] in_imvalue;
    logic [31:0] in_op1, in_op2;
    logic [31:0] alu_in1, alu_in2;
    logic [3:0]  alu_cond, alu_opcode;
    logic        alu_sbit;
    logic [2:0]  alu_srcontrol;
    logic [15:0] alu_imvalue;
    logic [3:0]  alu_inflags;
    logic [31:0] alu_result;
    logic [3:0]  alu_outflags;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        out_valid, out_ready;
    logic [31:0] out_result;
    logic        out_wb_en;
    logic [3:0]  flags;
    logic        busy;
`ifdef ALU_ISSUE_PERF_EN
    logic [31:0] perf_retired, perf_skipped;
`endif

    always #5 clk = ~clk;

    alu_issue_ctrl #(.MUL_LAT(MUL_LAT), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_cond(in_cond), .in_opcode(in_opcode), .in_sbit(in_sbit),
        .in_srcontrol(in_srcontrol), .in_imvalue(in_imvalue),
        .in_op1(in_op1), .in_op2(in_op2),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_cond(alu_cond), .alu_opcode(alu_opcode),
        .alu_sbit(alu_sbit), .alu_srcontrol(alu_srcontrol), .alu_imvalue(alu_imvalue),
        .alu_inflags(alu_inflags), .alu_result(alu_result), .alu_outflags(alu_outflags),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_wb_en(out_wb_en), .flags(flags),
`ifdef ALU_ISSUE_PERF_EN
        .perf_retired(perf_retired), .perf_skipped(perf_skipped),
`endif
        .busy(busy)
    );

    typedef struct {
        logic [3:0]  cond;
        logic [3:0]  opcode;
        logic        sbit;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [15:0] imm;
        logic [31:0] alu_res;
        logic [3:0]  alu_fl;
        logic [31:0] exp_res;
        logic        exp_wb;
        logic [3:0]  exp_flags;
        int          exp_lat;
    } vec_t;

    vec_t vecs[18];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the negedge after the accept edge.
    task automatic issue(input vec_t v);
        int guard = 0;
        while (!in_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("in_ready_before_issue", 32'(in_ready), 32'd1);
        in_valid     = 1'b1;
        in_cond      = v.cond;
        in_opcode    = v.opcode;
        in_sbit      = v.sbit;
        in_srcontrol = 3'b101;
        in_imvalue   = v.imm;
        in_op1       = v.op1;
        in_op2       = v.op2;
        alu_result   = v.alu_res;
        alu_outflags = v.alu_fl;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        in_op1   = 32'hFFFF_FFFF;
        in_op2   = 32'hFFFF_FFFF;
    endtask

    task automatic retire(input string tag);
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, "_valid_after_hs"}, 32'(out_valid), 32'd0);
        check({tag, "_idle_after_hs"}, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        int lat = 1;
        issue(v);
        while (!out_valid && lat < 20) begin
            check({tag, "_busy"}, 32'(busy), 32'd1);
            check({tag, "_in_ready_low"}, 32'(in_ready), 32'd0);
            @(negedge clk);
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'(v.exp_lat));
        check({tag, "_result"}, out_result, v.exp_res);
        check({tag, "_wb_en"}, 32'(out_wb_en), 32'(v.exp_wb));
        check({tag, "_flags"}, 32'(flags), 32'(v.exp_flags));
        check({tag, "_alu_inflags"}, 32'(alu_inflags), 32'(v.exp_flags));
        check({tag, "_alu_in1"}, alu_in1, v.op1);
        check({tag, "_alu_in2"}, alu_in2, v.op2);
        check({tag, "_alu_opcode"}, 32'(alu_opcode), 32'(v.opcode));
        check({tag, "_alu_srcontrol"}, 32'(alu_srcontrol), 32'd5);
        check({tag, "_mem_req"}, 32'(mem_req), 32'd0);
        retire(tag);
    endtask

    initial begin
        vec_t v;
        logic [31:0] held;
        // cond opcode sbit op1 op2 imm alu_res alu_fl exp_res exp_wb exp_flags exp_lat
        vecs[0]  = '{4'h0, 4'h0, 1'b1, 32'd5, 32'd7, 16'h0, 32'd12, 4'b0000, 32'd12, 1'b1, 4'b0000, 2};
        vecs[1]  = '{4'h0, 4'h1, 1'b1, 32'd3, 32'd3, 16'h0, 32'd0,  4'b0100, 32'd0,  1'b1, 4'b0100, 2};
        vecs[2]  = '{4'h1, 4'h0, 1'b0, 32'd1, 32'd1, 16'h0, 32'd2,  4'b0000, 32'd2,  1'b1, 4'b0100, 2};
        vecs[3]  = '{4'h2, 4'h0, 1'b1, 32'd1, 32'd1, 16'h0, 32'd2,  4'b0000, 32'd0,  1'b0, 4'b0100, 2};
        vecs[4]  = '{4'h0, 4'h8, 1'b0, 32'd5, 32'd3, 16'h0, 32'd2,  4'b0010, 32'd2,  1'b0, 4'b0010, 2};
        vecs[5]  = '{4'h7, 4'h0, 1'b1, 32'd2, 32'd3, 16'h0, 32'd5,  4'b1111, 32'd0,  1'b0, 4'b0010, 2};
        vecs[6]  = '{4'h8, 4'h0, 1'b1, 32'd4, 32'd5, 16'h0, 32'd9,  4'b1000, 32'd9,  1'b1, 4'b1000, 2};
        vecs[7]  = '{4'h5, 4'h0, 1'b0, 32'd1, 32'd2, 16'h0, 32'd3,  4'b0000, 32'd3,  1'b1, 4'b1000, 2};
        vecs[8]  = '{4'h0, 4'hF, 1'b1, 32'd9, 32'd9, 16'h0, 32'd77, 4'b0101, 32'd0,  1'b0, 4'b1000, 2};
        vecs[9]  = '{4'h0, 4'hC, 1'b1, 32'd8, 32'd8, 16'h0, 32'd88, 4'b0101, 32'd0,  1'b0, 4'b1000, 2};
        vecs[10] = '{4'h4, 4'h0, 1'b1, 32'd2, 32'd2, 16'h0, 32'd4,  4'b0000, 32'd0,  1'b0, 4'b1000, 2};
        vecs[11] = '{4'h0, 4'h2, 1'b1, 32'd6, 32'd7, 16'h0, 32'd42, 4'b0000, 32'd42, 1'b1, 4'b0000, MUL_LAT + 1};
        vecs[12] = '{4'h3, 4'h0, 1'b1, 32'd0, 32'd1, 16'h0, 32'd1,  4'b1111, 32'd0,  1'b0, 4'b0000, 2};
        vecs[13] = '{4'h0, 4'h1, 1'b1, 32'd9, 32'd4, 16'h0, 32'd5,  4'b0001, 32'd5,  1'b1, 4'b0001, 2};
        vecs[14] = '{4'h3, 4'h0, 1'b0, 32'd5, 32'd6, 16'h0, 32'd11, 4'b0000, 32'd11, 1'b1, 4'b0001, 2};
        vecs[15] = '{4'h6, 4'h0, 1'b1, 32'd3, 32'd3, 16'h0, 32'd6,  4'b0110, 32'd0,  1'b0, 4'b0001, 2};
        vecs[16] = '{4'h9, 4'h0, 1'b1, 32'd6, 32'd7, 16'h0, 32'd13, 4'b0011, 32'd13, 1'b1, 4'b0011, 2};
        vecs[17] = '{4'h1, 4'h2, 1'b1, 32'd9, 32'd11, 16'h0, 32'd99, 4'b0000, 32'd0, 1'b0, 4'b0011, 2};

        reset = 1'b0; in_valid = 1'b0; in_cond = '0; in_opcode = '0; in_sbit = 1'b0;
        in_srcontrol = '0; in_imvalue = '0; in_op1 = '0; in_op2 = '0;
        alu_result = '0; alu_outflags = '0; mem_ack = 1'b0; mem_rdata = '0; out_ready = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_result", out_result, 32'd0);
        check("rst_out_wb_en", 32'(out_wb_en), 32'd0);
        check("rst_flags", 32'(flags), 32'd0);
        check("rst_mem_req", 32'(mem_req), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_alu_in1", alu_in1, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 18; i++)
            run_vec(vecs[i], $sformatf("v%0d", i));

        // LDR with an early ack during EXEC that must be ignored, then a 4-cycle ack delay
        v = '{4'h0, 4'h9, 1'b1, 32'h100, 32'h55, 16'h0004, 32'h1234, 4'b1111, 32'hDEADBEEF, 1'b1, 4'b0011, 0};
        issue(v);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("ldr_mem_req", 32'(mem_req), 32'd1);
            check("ldr_mem_we", 32'(mem_we), 32'd0);
            check("ldr_mem_addr", mem_addr, 32'h104);
            check("ldr_out_valid_low", 32'(out_valid), 32'd0);
            if (k == 3) begin
                mem_ack   = 1'b1;
                mem_rdata = 32'hDEADBEEF;
            end
            @(negedge clk);
        end
        mem_ack = 1'b0;
        check("ldr_out_valid", 32'(out_valid), 32'd1);
        check("ldr_result", out_result, 32'hDEADBEEF);
        check("ldr_wb_en", 32'(out_wb_en), 32'd1);
        check("ldr_mem_req_drop", 32'(mem_req), 32'd0);
        check("ldr_flags", 32'(flags), 32'b0011);
        retire("ldr");

        v = '{4'h0, 4'hA, 1'b1, 32'h200, 32'hCAFEF00D, 16'h0010, 32'h77, 4'b1111, 32'd0, 1'b0, 4'b0011, 0};
        issue(v);
        @(negedge clk);
        check("str_mem_req", 32'(mem_req), 32'd1);
        check("str_mem_we", 32'(mem_we), 32'd1);
        check("str_mem_addr", mem_addr, 32'h210);
        check("str_mem_wdata", mem_wdata, 32'hCAFEF00D);
        mem_ack = 1'b1;
        mem_rdata = 32'h1111_2222;
        @(negedge clk);
        mem_ack = 1'b0;
        check("str_out_valid", 32'(out_valid), 32'd1);
        check("str_result", out_result, 32'd0);
        check("str_wb_en", 32'(out_wb_en), 32'd0);
        check("str_flags", 32'(flags), 32'b0011);
        retire("str");

        // Writeback backpressure: DONE holds for 5 cycles even with a new instruction offered
        v = '{4'h0, 4'h0, 1'b0, 32'd20, 32'd22, 16'h0, 32'd42, 4'b0000, 32'd42, 1'b1, 4'b0011, 0};
        issue(v);
        @(negedge clk);
        held = out_result;
        in_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_result", out_result, 32'd42);
            check("bp_result_stable", out_result, held);
            check("bp_in_ready_low", 32'(in_ready), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        retire("bp");

        // Async reset while in MEM
        v = '{4'h0, 4'h9, 1'b0, 32'h300, 32'h0, 16'h0008, 32'h0, 4'b0000, 32'd0, 1'b0, 4'b0011, 0};
        issue(v);
        @(negedge clk);
        check("rstmem_mem_req_before", 32'(mem_req), 32'd1);
        check("rstmem_flags_before", 32'(flags), 32'b0011);
        #2 reset = 1'b0;
        #1;
        check("rstmem_mem_req", 32'(mem_req), 32'd0);
        check("rstmem_flags", 32'(flags), 32'd0);
        check("rstmem_busy", 32'(busy), 32'd0);
        check("rstmem_out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("rstmem_in_ready", 32'(in_ready), 32'd1);

`ifdef ALU_ISSUE_PERF_EN
        check("perf_retired_rst", perf_retired, 32'd0);
        check("perf_skipped_rst", perf_skipped, 32'd0);
        v = '{4'h0, 4'h0, 1'b0, 32'd1, 32'd2, 16'h0, 32'd3, 4'b0000, 32'd3, 1'b1, 4'b0000, 2};
        run_vec(v, "perf_a");
        run_vec(v, "perf_b");
        v.cond = 4'h1; v.exp_res = 32'd0; v.exp_wb = 1'b0;
        run_vec(v, "perf_skip");
        v.cond = 4'h0; v.exp_res = 32'd3; v.exp_wb = 1'b1;
        run_vec(v, "perf_c");
        check("perf_retired", perf_retired, 32'd3);
        check("perf_skipped", perf_skipped, 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/alu_issue_ctrl.md
Name: alu_issue_ctrl

Overview:
- Multi-cycle sequencer that sits in front of the 32-bit ALU.
- Accepts one decoded instruction per valid/ready handshake and latches its fields. Drives the ALU inputs from those latches and holds the architectural NZCV flag register that feeds the ALU's inflags.
- Stalls for multiply latency, runs a memory handshake for LDR/STR, and presents the result to writeback through a valid/ready handshake.

Parameters:
- MUL_LAT, 3, cycles a MUL (opcode 0010) holds in EXEC before capture (≥1).
- DATA_W, 32, operand/result width.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  controller can accept.
- in_cond / in_opcode  in  4 / 4  condition and opcode, ALU encoding.
- in_sbit  in  1  update flags.
- in_srcontrol  in  3  shift/rotate select.
- in_imvalue  in  16  immediate.
- in_op1 / in_op2  in  32 / 32  register operands.
- alu_in1, alu_in2, alu_cond, alu_opcode, alu_sbit, alu_srcontrol, alu_imvalue  out  matching widths  latched fields to the ALU.
- alu_inflags  out  4  current flag register {N,Z,C,V}.
- alu_result  in  32  ALU result.
- alu_outflags  in  4  ALU flags.
- mem_req  out  1  memory request.
- mem_we  out  1  1 = store.
- mem_addr  out  32  op1 + zero-extended imvalue.
- mem_wdata  out  32  op2.
- mem_ack  in  1  request completed.
- mem_rdata  in  32  load data.
- out_valid  out  1  result available.
- out_ready  in  1  writeback accepts.
- out_result  out  32  captured result.
- out_wb_en  out  1  result must be written.
- flags  out  4  flag register (same as alu_inflags).
- busy  out  1  state != IDLE.

Behaviour:
- Reset (reset=0, async): state=IDLE, all latches=0, flags=4'b0000, out_valid=0, out_result=0, out_wb_en=0, mem_req=0, mem_we=0, busy=0, mul counter=0. in_ready=1 once reset deasserts.
- cond_met is computed from the latched cond against the flag register. Encodings:
  - 0001: Z.
  - 0010: !Z & (N==V).
  - 0011: !Z & (N!=V).
  - 0100: N==V.
  - 0101: N!=V.
  - 0110: !Z & C.
  - 0111: !C.
  - 1000: C.
  - other: always met.
- IDLE: in_ready=1. When in_valid=1, latch all fields on the edge and go to EXEC. in_ready=0 in every other state.
- EXEC: ALU outputs reflect the latches.
  - If !cond_met: skip. Go to DONE with out_wb_en=0, out_result=0, flags unchanged, no mem_req.
  - MUL: counter counts MUL_LAT-1 extra cycles. On the final EXEC edge, capture alu_result and go to DONE.
  - LDR (1001) / STR (1010): go to MEM.
  - CMP (1000): capture; out_wb_en=0.
  - NOP (1111): out_wb_en=0, flags unchanged.
  - All other opcodes: capture on the first EXEC edge; out_wb_en=1.
  - Latency, in_valid accepted to out_valid: 2 cycles for single-cycle ops, MUL_LAT+1 for MUL.
- Flag update: at capture, flags <= alu_outflags only if sbit=1, cond_met=1 and opcode is not LDR/STR/NOP. CMP always updates flags regardless of sbit.
- MEM: mem_req=1 and mem_we=(opcode==STR), with mem_addr and mem_wdata stable, until mem_ack=1 is sampled.
  - On ack: LDR captures mem_rdata with out_wb_en=1. STR captures 0 with out_wb_en=0. Go to DONE.
  - mem_ack while not in MEM is ignored.
- DONE: out_valid=1, with out_result and out_wb_en stable. On out_valid & out_ready go to IDLE. No new instruction is accepted in the same cycle (no bypass).
- Reset mid-operation aborts immediately: mem_req drops asynchronously and the flag update is lost.
- Unlisted opcodes (1011–1110) act as NOP.

Optional Feature:
- Macro ALU_ISSUE_PERF_EN.
- When defined, adds output ports perf_retired[31:0] and perf_skipped[31:0], both reset to 0.
  - perf_retired increments on each DONE handshake with cond_met=1.
  - perf_skipped increments on each DONE handshake with cond_met=0.
  - Both wrap 0xFFFFFFFF→0.
- When not defined, the ports and counters are absent; all other behaviour is identical.

Test Plan:
- ADD op1=5, op2=7, sbit=1, cond=0000 → out_valid 2 cycles after accept, out_result=12, out_wb_en=1, flags=0000.
- SUB op1=3, op2=3, sbit=1 → result 0, flags Z=1. Then ADD cond=0001 (EQ) op1=1, op2=1 → result 2. Then ADD cond=0010 (GT) → skipped: out_wb_en=0, flags stay Z=1.
- MUL op1=6, op2=7 with MUL_LAT=3 → busy for 3 EXEC cycles, out_result=42, in_ready=0 throughout.
- LDR op1=0x100, imvalue=0x0004, mem_ack delayed 4 cycles, rdata=0xDEADBEEF → mem_addr=0x104 and mem_req held 4 cycles, out_result=0xDEADBEEF, out_wb_en=1. STR → mem_we=1, mem_wdata=op2, out_wb_en=0.
- out_ready held 0 for 5 cycles in DONE → out_result stable and in_ready=0. Pulse reset low during MEM → mem_req=0 and flags=0000 immediately.
- With ALU_ISSUE_PERF_EN: 3 executed and 1 skipped instruction → perf_retired=3, perf_skipped=1.
